instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of encoded-word buffer entries (power of two, >=2).
REQ-002 Parameter IMEM_AW, default 10, SHALL set the instruction-memory word-address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL indicate that an encode request is present.
REQ-006 req_ready  out  1  SHALL indicate that the block accepts the request this cycle.
REQ-007 req_kind  in  3  SHALL select the format: 0 ALU_R, 1 ALU_I, 2 BRANCH_EQ, 3 JUMP, 4 LOAD, 5 STORE; 6-7 are invalid.
REQ-008 req_rd, req_rs1, req_rs2  in  5 each  SHALL carry the register fields.
REQ-009 req_funct3  in  3; req_funct7  in  7  SHALL carry the function fields.
REQ-010 req_imm  in  32  SHALL carry the signed byte-offset/immediate.
REQ-011 imem_wr_en  out  1  SHALL be the write strobe toward instruction memory.
REQ-012 imem_wr_ready  in  1  SHALL indicate that memory accepts the write this cycle.
REQ-013 imem_wr_addr  out  IMEM_AW  SHALL be the word address of the current write.
REQ-014 imem_wr_data  out  32  SHALL be the encoded instruction word.
REQ-015 err_kind  out  1  SHALL pulse for one cycle when an invalid kind is accepted.
REQ-016 mem_full  out  1  SHALL be a sticky flag set when address space is exhausted.

Function
REQ-017 A request SHALL be accepted when req_valid && req_ready.
REQ-018 req_ready SHALL equal !fifo_full && !mem_full; a pop in the same cycle SHALL NOT free space for a push (no pass-through when full).
REQ-019 Encoding SHALL be combinational on request fields, and the word SHALL be registered into the FIFO on acceptance.
REQ-020 ALU_R SHALL encode as funct7|rs2|rs1|funct3|rd|0110011.
REQ-021 ALU_I SHALL encode as imm[11:0]|rs1|funct3|rd|0010011.
REQ-022 LOAD SHALL encode as imm[11:0]|rs1|funct3|rd|0000011.
REQ-023 STORE SHALL encode as imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011.
REQ-024 BRANCH_EQ SHALL encode as imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011; imm[0] SHALL be ignored.
REQ-025 JUMP SHALL encode as imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111; imm[0] SHALL be ignored.
REQ-026 Immediate bits above each format's range SHALL be ignored, with no range error.
REQ-027 An invalid kind SHALL be accepted and not enqueued, and err_kind SHALL be 1 in the following cycle only.
REQ-028 imem_wr_en SHALL equal FIFO not-empty; imem_wr_data/addr SHALL show the FIFO head and address counter.
REQ-029 A write SHALL complete when imem_wr_en && imem_wr_ready; the FIFO SHALL pop and the address SHALL increment by 1.
REQ-030 Minimum latency SHALL be 1 cycle: a request accepted in cycle N SHALL reach imem_wr_en=1 in cycle N+1.
REQ-031 Sustained throughput SHALL be one word per cycle while imem_wr_ready=1.
REQ-032 Output fields SHALL remain stable while imem_wr_en=1 && imem_wr_ready=0.
REQ-033 Completing a write at address 2^IMEM_AW-1 SHALL set mem_full and hold the address at that value without wrapping.
REQ-034 While mem_full=1, buffered words SHALL be discarded without writing and imem_wr_en SHALL be 0.
REQ-035 Simultaneous push and pop with the FIFO neither full nor empty SHALL leave the occupancy unchanged.

Reset
REQ-036 rst SHALL clear the FIFO, the address counter (0), mem_full, err_kind and imem_wr_en in the same edge, taking priority over all traffic, including mid-burst.
REQ-037 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-038 ALU_R rd=3 rs1=1 rs2=2 f3=0 f7=0, ready=1 -> next cycle wr_en=1, addr=0, data=0x002081B3.
REQ-039 ALU_I rd=5 rs1=0 imm=-1, then STORE rs1=1 rs2=2 f3=2 imm=4 -> 0xFFF00293 @0, 0x0020A223 @1.
REQ-040 BRANCH_EQ rs1=1 rs2=2 imm=8 -> 0x00208463; JUMP rd=1 imm=16 -> 0x010000EF.
REQ-041 imem_wr_ready=0, 5 back-to-back requests -> 4 accepted, req_ready=0 on the 5th, data stable; release ready -> 4 writes at addr 0..3 in order.
REQ-042 kind=7 -> no write, err_kind=1 for exactly one cycle; IMEM_AW=2, 5 requests -> writes at 0..3, mem_full=1, 5th word discarded, req_ready=0.
REQ-043 rst asserted with 3 words buffered -> next cycle wr_en=0, addr=0, mem_full=0, req_ready=1.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes RISC-V style instruction requests into 32-bit words, buffers them in a
// small FIFO and streams them to instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int IMEM_AW    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_kind,
    input  logic [4:0]         req_rd,
    input  logic [4:0]         req_rs1,
    input  logic [4:0]         req_rs2,
    input  logic [2:0]         req_funct3,
    input  logic [6:0]         req_funct7,
    input  logic [31:0]        req_imm,
    output logic               imem_wr_en,
    input  logic               imem_wr_ready,
    output logic [IMEM_AW-1:0] imem_wr_addr,
    output logic [31:0]        imem_wr_data,
    output logic               err_kind,
    output logic               mem_full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] KIND_ALU_R  = 3'd0;
    localparam logic [2:0] KIND_ALU_I  = 3'd1;
    localparam logic [2:0] KIND_BRANCH = 3'd2;
    localparam logic [2:0] KIND_JUMP   = 3'd3;
    localparam logic [2:0] KIND_LOAD   = 3'd4;
    localparam logic [2:0] KIND_STORE  = 3'd5;

    localparam logic [PTR_W:0]   PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [IMEM_AW-1:0] ADDR_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};
    localparam logic [IMEM_AW-1:0] ADDR_MAX = {IMEM_AW{1'b1}};

    function automatic logic [31:0] encode_word(
        input logic [2:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] word;
        case (kind)
            KIND_ALU_R:  word = {f7, rs2, rs1, f3, rd, 7'b0110011};
            KIND_ALU_I:  word = {imm[11:0], rs1, f3, rd, 7'b0010011};
            KIND_LOAD:   word = {imm[11:0], rs1, f3, rd, 7'b0000011};
            KIND_STORE:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            KIND_JUMP:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            default:     word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    logic [31:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_r;
    logic [PTR_W:0]     rd_ptr_r;
    logic [IMEM_AW-1:0] addr_r;
    logic               mem_full_r;
    logic               err_kind_r;

    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        kind_ok_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic        write_done_s;
    logic [31:0] enc_word_s;
    logic        unused_imm_s;

    assign unused_imm_s = ^req_imm[31:21];

    // Handshake, encode and pop decisions derived from current state and request.
    always_comb begin
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
        kind_ok_s    = (req_kind <= KIND_STORE);
        enc_word_s   = encode_word(req_kind, req_rd, req_rs1, req_rs2,
                                   req_funct3, req_funct7, req_imm);
        req_ready    = !fifo_full_s && !mem_full_r;
        accept_s     = req_valid && req_ready;
        push_s       = accept_s && kind_ok_s;
        imem_wr_en   = !fifo_empty_s && !mem_full_r;
        write_done_s = imem_wr_en && imem_wr_ready;
        // Once memory is exhausted, leftover words drain without being written.
        pop_s        = write_done_s || (mem_full_r && !fifo_empty_s);
    end

    assign imem_wr_data = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
    assign imem_wr_addr = addr_r;
    assign err_kind     = err_kind_r;
    assign mem_full     = mem_full_r;

    // Word storage; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= enc_word_s;
        end
    end

    // Pointers, address counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {(PTR_W+1){1'b0}};
            rd_ptr_r   <= {(PTR_W+1){1'b0}};
            addr_r     <= {IMEM_AW{1'b0}};
            mem_full_r <= 1'b0;
            err_kind_r <= 1'b0;
        end else begin
            err_kind_r <= accept_s && !kind_ok_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (write_done_s) begin
                if (addr_r == ADDR_MAX) begin
                    mem_full_r <= 1'b1;
                end else begin
                    addr_r <= addr_r + ADDR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder, checked against a queue-based
// reference model; a second instance with IMEM_AW=2 exercises address exhaustion.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_kind = 3'd0;
    logic [4:0]  req_rd = 5'd0, req_rs1 = 5'd0, req_rs2 = 5'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [6:0]  req_funct7 = 7'd0;
    logic [31:0] req_imm = 32'd0;
    logic        imem_wr_ready = 1'b0;

    logic        req_ready, imem_wr_en, err_kind, mem_full;
    logic [9:0]  imem_wr_addr;
    logic [31:0] imem_wr_data;

    logic        s_req_ready, s_wr_en, s_err_kind, s_mem_full;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_encoder #(.FIFO_DEPTH(4), .IMEM_AW(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
        .imem_wr_en(imem_wr_en), .imem_wr_ready(imem_wr_ready),
        .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
        .err_kind(err_kind), .mem_full(mem_full)
    );

    instr_encoder #(.FIFO_DEPTH(4), .IMEM_AW(2)) dut_small (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
        .imem_wr_en(s_wr_en), .imem_wr_ready(imem_wr_ready),
        .imem_wr_addr(s_wr_addr), .imem_wr_data(s_wr_data),
        .err_kind(s_err_kind), .mem_full(s_mem_full)
    );

    // Reference encoder built from field placement arithmetic.
    function automatic logic [31:0] ref_encode(input logic [31:0] kind, input logic [31:0] rd,
        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
        input logic [31:0] f7, input logic [31:0] imm);
        logic [31:0] common;
        common = (rs1 << 15) | (f3 << 12);
        case (kind)
            32'd0: return (f7 << 25) | (rs2 << 20) | common | (rd << 7) | 32'h33;
            32'd1: return ((imm & 32'hFFF) << 20) | common | (rd << 7) | 32'h13;
            32'd4: return ((imm & 32'hFFF) << 20) | common | (rd << 7) | 32'h03;
            32'd5: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | common |
                          ((imm & 32'h1F) << 7) | 32'h23;
            32'd2: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                          (rs2 << 20) | common | (((imm >> 1) & 32'hF) << 8) |
                          (((imm >> 11) & 32'h1) << 7) | 32'h63;
            32'd3: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                          (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                          (rd << 7) | 32'h6F;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        req_valid = 1'b1; req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_funct3 = f3; req_funct7 = f7; req_imm = imm;
    endtask

    task automatic drive_random_req(output logic [31:0] word);
        drive_req(3'(($urandom_range(0, 5))), 5'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), 7'($urandom), $urandom);
        word = ref_encode(32'(req_kind), 32'(req_rd), 32'(req_rs1), 32'(req_rs2),
                          32'(req_funct3), 32'(req_funct7), req_imm);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; imem_wr_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", imem_wr_en); else n_pass++;
        n_checks++; if (imem_wr_addr !== 10'd0) $display("FAIL reset_addr got %0d want 0", imem_wr_addr); else n_pass++;
        n_checks++; if (mem_full !== 1'b0) $display("FAIL reset_mem_full got %b want 0", mem_full); else n_pass++;
        n_checks++; if (err_kind !== 1'b0) $display("FAIL reset_err_kind got %b want 0", err_kind); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_directed();
        do_reset();
        imem_wr_ready = 1'b1;
        drive_req(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        step(); req_valid = 1'b0;
        n_checks++; if (imem_wr_en !== 1'b1 || imem_wr_addr !== 10'd0 || imem_wr_data !== 32'h002081B3)
            $display("FAIL alu_r en=%b addr=%0d data=%h want 1/0/002081b3", imem_wr_en, imem_wr_addr, imem_wr_data); else n_pass++;
        do_reset();
        imem_wr_ready = 1'b1;
        drive_req(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        step();
        n_checks++; if (imem_wr_addr !== 10'd0 || imem_wr_data !== 32'hFFF00293)
            $display("FAIL alu_i addr=%0d data=%h want 0/fff00293", imem_wr_addr, imem_wr_data); else n_pass++;
        drive_req(3'd5, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4);
        step();
        n_checks++; if (imem_wr_addr !== 10'd1 || imem_wr_data !== 32'h0020A223)
            $display("FAIL store addr=%0d data=%h want 1/0020a223", imem_wr_addr, imem_wr_data); else n_pass++;
        drive_req(3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd9);
        step();
        n_checks++; if (imem_wr_addr !== 10'd2 || imem_wr_data !== 32'h00208463)
            $display("FAIL branch addr=%0d data=%h want 2/00208463", imem_wr_addr, imem_wr_data); else n_pass++;
        drive_req(3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd17);
        step(); req_valid = 1'b0;
        n_checks++; if (imem_wr_addr !== 10'd3 || imem_wr_data !== 32'h010000EF)
            $display("FAIL jump addr=%0d data=%h want 3/010000ef", imem_wr_addr, imem_wr_data); else n_pass++;
        step();
        n_checks++; if (imem_wr_en !== 1'b0 || imem_wr_addr !== 10'd4)
            $display("FAIL drained en=%b addr=%0d want 0/4", imem_wr_en, imem_wr_addr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_random_req(exp_w[i]);
            n_checks++; if (req_ready !== (i < 4))
                $display("FAIL bp_ready[%0d] got %b want %b", i, req_ready, (i < 4)); else n_pass++;
            if (i > 0) begin
                n_checks++; if (imem_wr_en !== 1'b1 || imem_wr_data !== exp_w[0])
                    $display("FAIL bp_stable[%0d] en=%b data=%h want 1/%h", i, imem_wr_en, imem_wr_data, exp_w[0]); else n_pass++;
            end
            step();
        end
        req_valid = 1'b0; imem_wr_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (imem_wr_en !== 1'b1 || imem_wr_addr !== 10'(j) || imem_wr_data !== exp_w[j])
                $display("FAIL bp_write[%0d] en=%b addr=%0d data=%h want 1/%0d/%h", j, imem_wr_en, imem_wr_addr, imem_wr_data, j, exp_w[j]); else n_pass++;
            step();
        end
        n_checks++; if (imem_wr_en !== 1'b0) $display("FAIL bp_empty en=%b want 0", imem_wr_en); else n_pass++;
    endtask

    task automatic test_invalid_kind();
        do_reset();
        imem_wr_ready = 1'b1;
        drive_req(3'd7, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'h55);
        step(); req_valid = 1'b0;
        n_checks++; if (err_kind !== 1'b1 || imem_wr_en !== 1'b0)
            $display("FAIL invalid_first err=%b en=%b want 1/0", err_kind, imem_wr_en); else n_pass++;
        step();
        n_checks++; if (err_kind !== 1'b0 || imem_wr_en !== 1'b0 || imem_wr_addr !== 10'd0)
            $display("FAIL invalid_second err=%b en=%b addr=%0d want 0/0/0", err_kind, imem_wr_en, imem_wr_addr); else n_pass++;
    endtask

    task automatic test_mem_full();
        logic [31:0] exp_w [5];
        int nwr = 0;
        do_reset();
        imem_wr_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (s_wr_en) begin
                n_checks++; if (nwr > 3 || s_wr_addr !== 2'(nwr) || s_wr_data !== exp_w[nwr])
                    $display("FAIL full_write[%0d] addr=%0d data=%h want %0d", nwr, s_wr_addr, s_wr_data, nwr); else n_pass++;
                nwr++;
            end
            if (c < 5) drive_random_req(exp_w[c]);
            else req_valid = 1'b0;
            step();
        end
        n_checks++; if (nwr !== 4) $display("FAIL full_count got %0d want 4", nwr); else n_pass++;
        n_checks++; if (s_mem_full !== 1'b1 || s_req_ready !== 1'b0 || s_wr_en !== 1'b0 || s_wr_addr !== 2'd3)
            $display("FAIL full_state full=%b ready=%b en=%b addr=%0d want 1/0/0/3", s_mem_full, s_req_ready, s_wr_en, s_wr_addr); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_random_req(w);
            step();
        end
        rst = 1'b1; imem_wr_ready = 1'b1;
        step();
        rst = 1'b0; req_valid = 1'b0;
        n_checks++; if (imem_wr_en !== 1'b0 || imem_wr_addr !== 10'd0 || mem_full !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL mid_reset en=%b addr=%0d full=%b ready=%b want 0/0/0/1", imem_wr_en, imem_wr_addr, mem_full, req_ready); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] w;
        int   m_addr = 0;
        logic m_err = 1'b0;
        logic acc;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            n_checks++; if (req_ready !== (q.size() < 4))
                $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, (q.size() < 4)); else n_pass++;
            n_checks++; if (imem_wr_en !== (q.size() > 0))
                $display("FAIL rnd_wr_en c=%0d got %b want %b", c, imem_wr_en, (q.size() > 0)); else n_pass++;
            n_checks++; if (err_kind !== m_err)
                $display("FAIL rnd_err c=%0d got %b want %b", c, err_kind, m_err); else n_pass++;
            n_checks++; if (imem_wr_addr !== 10'(m_addr))
                $display("FAIL rnd_addr c=%0d got %0d want %0d", c, imem_wr_addr, m_addr); else n_pass++;
            if (q.size() > 0) begin
                n_checks++; if (imem_wr_data !== q[0])
                    $display("FAIL rnd_data c=%0d got %h want %h", c, imem_wr_data, q[0]); else n_pass++;
            end
            drive_random_req(w);
            if ($urandom_range(0, 7) == 0) req_kind = 3'($urandom_range(6, 7));
            req_valid = ($urandom_range(0, 3) != 0);
            imem_wr_ready = ($urandom_range(0, 2) != 0);
            acc = req_valid && (q.size() < 4);
            m_err = acc && (req_kind > 3'd5);
            if (q.size() > 0 && imem_wr_ready) begin
                void'(q.pop_front());
                m_addr++;
            end
            if (acc && req_kind <= 3'd5) q.push_back(w);
            step();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_invalid_kind();
        test_mem_full();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
